// File: rtl/register_file_pkg.sv
// Shared constants and types for the MIPS-style register file.
package register_file_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Read/write bus of the register file; master drives addresses and writeback data.
import register_file_pkg::*;

interface register_file_if #(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] address_s1;
  logic [ADDR_WIDTH-1:0] address_s2;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] data_dval;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_s1val;
  logic [DATA_WIDTH-1:0] data_s2val;

  modport master (
    output address_s1, address_s2, address_d, data_dval, write_enable,
    input  data_s1val, data_s2val
  );

  modport slave (
    input  address_s1, address_s2, address_d, data_dval, write_enable,
    output data_s1val, data_s2val
  );
endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: 32:1 mux, r0 forced to zero, optional
// same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic [ADDR_WIDTH-1:0]                      addr_d,
  input  logic [DATA_WIDTH-1:0]                      data_d,
  input  logic                                       write_enable,
  input  logic                                       reset_n,
  output logic [DATA_WIDTH-1:0]                      data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data = regs[addr];
    if (addr == ZERO) data = '0;
    // write_enable gates the compare so an X/Z address_d cannot leak through
    if (reset_n && write_enable && (addr_d != ZERO) && (addr == addr_d))
      data = data_d;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{reset_n, write_enable, addr_d, data_d};

  always_comb begin
    data = regs[addr];
    if (addr == ZERO) data = '0;
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// r0 hardwired to zero. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic           clock,
  input  logic           reset_n,
  register_file_if.slave rf
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_view;

  assign regs_view[0] = '0;

  // Registers 1..DEPTH-1 each own a flop bank; r0 has no storage at all.
  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge clock) begin
      if (!reset_n)
        q <= '0;
      else if (rf.write_enable && (rf.address_d == ADDR_WIDTH'(g)))
        q <= rf.data_dval;
    end

    assign regs_view[g] = q;
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_s1 (
    .regs         (regs_view),
    .addr         (rf.address_s1),
    .addr_d       (rf.address_d),
    .data_d       (rf.data_dval),
    .write_enable (rf.write_enable),
    .reset_n      (reset_n),
    .data         (rf.data_s1val)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_s2 (
    .regs         (regs_view),
    .addr         (rf.address_s2),
    .addr_d       (rf.address_d),
    .data_d       (rf.data_dval),
    .write_enable (rf.write_enable),
    .reset_n      (reset_n),
    .data         (rf.data_s2val)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default and REGFILE_BYPASS_EN builds).
module tb_register_file;
  import register_file_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rf      (rf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    rf.write_enable = 1'b1;
    rf.address_d    = addr;
    rf.data_dval    = data;
    tick();
    rf.write_enable = 1'b0;
    rf.address_d    = 'x;
    rf.data_dval    = 'x;
  endtask

  task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
    rf.address_s1 = a1;
    rf.address_s2 = a2;
    #1;
  endtask

  initial begin
    logic [31:0] bypass_exp;
    checks = 0;
    errors = 0;
    reset_n         = 1'b1;
    rf.write_enable = 1'b0;
    rf.address_d    = '0;
    rf.data_dval    = '0;
    rf.address_s1   = '0;
    rf.address_s2   = '0;

    // Initial reset so storage is defined
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Fill every register with a distinct pattern and read it back
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h0101_0101 * i);
    for (int i = 1; i < 32; i++) begin
      read_both(5'(i), 5'(31 - i));
      check($sformatf("fill_s1_r%0d", i), rf.data_s1val, 32'h0101_0101 * i);
      check($sformatf("fill_s2_r%0d", 31 - i), rf.data_s2val,
            (i == 31) ? 32'h0 : 32'h0101_0101 * (31 - i));
    end

    // Reset with a simultaneous write: reset wins, everything clears
    reset_n         = 1'b0;
    rf.write_enable = 1'b1;
    rf.address_d    = 5'd3;
    rf.data_dval    = 32'h1234_5678;
    tick();
    rf.write_enable = 1'b0;
    reset_n         = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_both(5'(i), 5'(31 - i));
      check($sformatf("reset_s1_r%0d", i), rf.data_s1val, 32'h0);
      check($sformatf("reset_s2_r%0d", 31 - i), rf.data_s2val, 32'h0);
    end

    // Basic write/read
    write_reg(5'd31, 32'h0000_000F);
    read_both(5'd31, 5'd29);
    check("wr_r31", rf.data_s1val, 32'h0000_000F);
    check("wr_r29_untouched", rf.data_s2val, 32'h0);

    // Zero register: never forwarded, never stored
    read_both(5'd0, 5'd0);
    rf.write_enable = 1'b1;
    rf.address_d    = 5'd0;
    rf.data_dval    = 32'hDEAD_BEEF;
    #1;
    check("r0_during_write_s1", rf.data_s1val, 32'h0);
    check("r0_during_write_s2", rf.data_s2val, 32'h0);
    tick();
    rf.write_enable = 1'b0;
    read_both(5'd0, 5'd0);
    check("r0_after_s1", rf.data_s1val, 32'h0);
    check("r0_after_s2", rf.data_s2val, 32'h0);

    // Dual port, distinct and identical addresses
    write_reg(5'd5, 32'h1111_1111);
    write_reg(5'd6, 32'h2222_2222);
    read_both(5'd5, 5'd6);
    check("dual_s1_r5", rf.data_s1val, 32'h1111_1111);
    check("dual_s2_r6", rf.data_s2val, 32'h2222_2222);
    read_both(5'd6, 5'd6);
    check("same_s1_r6", rf.data_s1val, 32'h2222_2222);
    check("same_s2_r6", rf.data_s2val, 32'h2222_2222);

    // Write disabled: no store, no forwarding
    write_reg(5'd7, 32'h7777_7777);
    read_both(5'd7, 5'd7);
    rf.write_enable = 1'b0;
    rf.address_d    = 5'd7;
    rf.data_dval    = 32'hFFFF_FFFF;
    #1;
    check("we0_before_edge", rf.data_s1val, 32'h7777_7777);
    tick();
    check("we0_after_edge", rf.data_s2val, 32'h7777_7777);

    // Same-cycle write/read hazard
    write_reg(5'd3, 32'h0000_000A);
    read_both(5'd3, 5'd5);
    rf.write_enable = 1'b1;
    rf.address_d    = 5'd3;
    rf.data_dval    = 32'h0000_000B;
    #1;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'h0000_000B;
`else
    bypass_exp = 32'h0000_000A;
`endif
    check("hazard_before_edge", rf.data_s1val, bypass_exp);
    check("hazard_other_port", rf.data_s2val, 32'h1111_1111);
    tick();
    rf.write_enable = 1'b0;
    check("hazard_after_edge", rf.data_s1val, 32'h0000_000B);

    // Reset mid-sequence with a pending write: no forwarding, then cleared
    write_reg(5'd9, 32'h0000_0099);
    read_both(5'd9, 5'd31);
    reset_n         = 1'b0;
    rf.write_enable = 1'b1;
    rf.address_d    = 5'd9;
    rf.data_dval    = 32'h0000_0055;
    #1;
    check("rst_write_before_edge", rf.data_s1val, 32'h0000_0099);
    tick();
    rf.write_enable = 1'b0;
    reset_n         = 1'b1;
    #1;
    check("rst_write_after_edge", rf.data_s1val, 32'h0);
    check("rst_clears_r31", rf.data_s2val, 32'h0);

    // Normal operation resumes after reset
    write_reg(5'd9, 32'hCAFE_F00D);
    read_both(5'd9, 5'd3);
    check("post_reset_write", rf.data_s1val, 32'hCAFE_F00D);
    check("post_reset_r3", rf.data_s2val, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
